// File: rtl/net_pkg.sv
// rtl/net_pkg.sv - shared constants and types for the framed serial link
package net_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h7E;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  localparam int unsigned IDX_SYNC = 0;
  localparam int unsigned IDX_HDR  = 1;
  localparam int unsigned IDX_LEN  = 2;
  localparam int unsigned IDX_PAY0 = 3;

  localparam int unsigned FRAME_OVERHEAD = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } tx_state_t;

endpackage

// File: rtl/crc8_update.sv
// rtl/crc8_update.sv - one-byte CRC-8 step, MSB-first, shared by tx and rx
module crc8_update
  import net_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/frame_tx_engine.sv
// rtl/frame_tx_engine.sv - framed 8N1 serial transmitter with length check and CRC-8 trailer
module frame_tx_engine
  import net_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_BYTES    = 16,
  parameter int ID_W         = 2,
  parameter int GAP_BITS     = 2,
  parameter int LEN_W        = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [8*MAX_BYTES-1:0] tx_data,
  input  logic [LEN_W-1:0]       tx_len,
  input  logic [ID_W-1:0]        tx_dest_id,
  input  logic [ID_W-1:0]        my_id,
  output logic                   tx_line,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx_len_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(MAX_BYTES + FRAME_OVERHEAD);
  localparam int GAP_W  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_BITS - 1);

  tx_state_t               state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [2:0]              bit_q, bit_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              shreg_q, shreg_d;
  logic [7:0]              crc_q, crc_d;
  logic [8*MAX_BYTES-1:0]  pay_q, pay_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [7:0]              hdr_q, hdr_d;
  logic                    line_q, line_d;
  logic                    busy_q, busy_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;
  logic                    len_err_q, len_err_d;

  logic                    baud_end;
  logic                    len_bad;
  logic                    frame_end;
  logic [IDX_W-1:0]        last_idx;
  logic [IDX_W-1:0]        nxt_idx;
  logic                    nxt_is_crc;
  logic [7:0]              nxt_byte;
  logic [7:0]              crc_next;

  assign baud_end = (baud_q == BAUD_LAST);
  assign len_bad  = ({1'b0, tx_len} > (LEN_W + 1)'(MAX_BYTES));
  assign last_idx = IDX_W'(IDX_PAY0) + IDX_W'(len_q);

  // Byte loaded at the next STOP boundary; payload is consumed from the low end of pay_q.
  always_comb begin
    nxt_idx    = idx_q + IDX_W'(1);
    nxt_is_crc = (nxt_idx == last_idx);
    if (nxt_idx == IDX_W'(IDX_HDR)) begin
      nxt_byte = hdr_q;
    end else if (nxt_idx == IDX_W'(IDX_LEN)) begin
      nxt_byte = 8'(len_q);
    end else begin
      nxt_byte = pay_q[7:0];
    end
  end

  crc8_update u_crc (
    .crc_in  (crc_q),
    .byte_in (nxt_byte),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      crc_q     <= CRC8_INIT;
      pay_q     <= '0;
      len_q     <= '0;
      hdr_q     <= '0;
      line_q    <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      crc_q     <= crc_d;
      pay_q     <= pay_d;
      len_q     <= len_d;
      hdr_q     <= hdr_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    crc_d     = crc_q;
    pay_d     = pay_q;
    len_d     = len_q;
    hdr_d     = hdr_q;
    line_d    = line_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    len_err_d = 1'b0;
    frame_end = 1'b0;

    if (state_q != ST_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        line_d  = 1'b1;
        if (tx_valid && ready_q) begin
          if (len_bad) begin
            len_err_d = 1'b1;
          end else begin
            state_d = ST_START;
            baud_d  = '0;
            idx_d   = IDX_W'(IDX_SYNC);
            shreg_d = SYNC_BYTE;
            crc_d   = CRC8_INIT;
            pay_d   = tx_data;
            len_d   = tx_len;
            hdr_d   = {4'(tx_dest_id), 4'(my_id)};
            line_d  = 1'b0;
            busy_d  = 1'b1;
            ready_d = 1'b0;
          end
        end
      end

      ST_START: begin
        if (baud_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          line_d  = shreg_q[0];
        end
      end

      ST_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            line_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            line_d  = shreg_q[1];
          end
        end
      end

      ST_STOP: begin
        if (baud_end) begin
          if (idx_q != last_idx) begin
            state_d = ST_START;
            line_d  = 1'b0;
            idx_d   = nxt_idx;
            if (nxt_is_crc) begin
              shreg_d = crc_q;
            end else begin
              shreg_d = nxt_byte;
              crc_d   = crc_next;
              if (nxt_idx >= IDX_W'(IDX_PAY0)) begin
                pay_d = pay_q >> 8;
              end
            end
          end else if (GAP_BITS == 0) begin
            frame_end = 1'b1;
          end else begin
            state_d = ST_GAP;
            line_d  = 1'b1;
            gap_d   = '0;
          end
        end
      end

      ST_GAP: begin
        if (baud_end) begin
          if (gap_q == GAP_LAST) begin
            frame_end = 1'b1;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Completion cycle: idle, ready and done all become visible together.
    if (frame_end) begin
      state_d = ST_IDLE;
      baud_d  = '0;
      bit_d   = '0;
      gap_d   = '0;
      idx_d   = '0;
      crc_d   = CRC8_INIT;
      line_d  = 1'b1;
      busy_d  = 1'b0;
      ready_d = 1'b1;
      done_d  = 1'b1;
    end
  end

  assign tx_line    = line_q;
  assign tx_busy    = busy_q;
  assign tx_ready   = ready_q;
  assign tx_done    = done_q;
  assign tx_len_err = len_err_q;

endmodule

// File: tb/tb_frame_tx_engine.sv
// tb/tb_frame_tx_engine.sv - self-checking bench for frame_tx_engine
module tb_frame_tx_engine;

  localparam int CPB  = 4;
  localparam int MAXB = 16;
  localparam int IDW  = 2;
  localparam int GAP  = 2;
  localparam int LW   = $clog2(MAXB + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [8*MAXB-1:0] tx_data = '0;
  logic [LW-1:0]     tx_len = '0;
  logic [IDW-1:0]    tx_dest_id = '0;
  logic [IDW-1:0]    my_id = '0;
  logic              tx_line;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_len_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] cu_crc_in = '0;
  logic [7:0] cu_byte_in = '0;
  logic [7:0] cu_crc_out;

  logic [7:0] exp_bytes[$];
  bit         exp_wave[$];

  always #5 clk = ~clk;

  frame_tx_engine #(
    .CLKS_PER_BIT (CPB),
    .MAX_BYTES    (MAXB),
    .ID_W         (IDW),
    .GAP_BITS     (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_len     (tx_len),
    .tx_dest_id (tx_dest_id),
    .my_id      (my_id),
    .tx_line    (tx_line),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_len_err (tx_len_err)
  );

  crc8_update u_crc_unit (
    .crc_in  (cu_crc_in),
    .byte_in (cu_byte_in),
    .crc_out (cu_crc_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: frame as a byte list, then as the per-cycle line level it must produce.
  task automatic build_expect(input logic [8*MAXB-1:0] d, input int len, input int dest, input int src);
    logic [7:0] c;
    logic [7:0] b;
    exp_bytes = {};
    exp_bytes.push_back(8'h7E);
    exp_bytes.push_back(8'((dest << 4) | src));
    exp_bytes.push_back(8'(len));
    for (int i = 0; i < len; i++) exp_bytes.push_back(d[8*i +: 8]);
    c = 8'h00;
    for (int i = 1; i < exp_bytes.size(); i++) begin
      c = c ^ exp_bytes[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    exp_bytes.push_back(c);
    exp_wave = {};
    for (int i = 0; i < exp_bytes.size(); i++) begin
      b = exp_bytes[i];
      for (int k = 0; k < 10; k++)
        for (int j = 0; j < CPB; j++)
          exp_wave.push_back((k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1]);
    end
    for (int j = 0; j < GAP * CPB; j++) exp_wave.push_back(1'b1);
  endtask

  task automatic start_frame(input string tag, input logic [8*MAXB-1:0] d, input int len,
                             input int dest, input int src);
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready before accept"}, tx_ready, 1'b1);
    build_expect(d, len, dest, src);
    tx_data    = d;
    tx_len     = LW'(len);
    tx_dest_id = IDW'(dest);
    my_id      = IDW'(src);
    tx_valid   = 1'b1;
    @(negedge clk);
  endtask

  // Entered at the first cycle after the accept edge; leaves in the completion cycle.
  task automatic check_frame(input string tag, input bit hold, input bit mutate,
                             input logic [8*MAXB-1:0] md, input int mlen, input int mdest, input int msrc);
    int n, bad_wave, bad_busy, bad_done;
    logic [7:0] got;
    bit samp[$];
    n = exp_wave.size();
    chk({tag, " start bit"}, tx_line, 1'b0);
    chk({tag, " busy at t+1"}, tx_busy, 1'b1);
    if (!hold) tx_valid = 1'b0;
    bad_wave = 0;
    bad_busy = 0;
    bad_done = 0;
    samp = {};
    for (int c = 0; c < n; c++) begin
      if (mutate && c == n / 2) begin
        tx_data    = md;
        tx_len     = LW'(mlen);
        tx_dest_id = IDW'(mdest);
        my_id      = IDW'(msrc);
      end
      samp.push_back(tx_line);
      if (tx_line !== exp_wave[c]) bad_wave++;
      if (tx_busy !== 1'b1 || tx_ready !== 1'b0) bad_busy++;
      if (tx_done !== 1'b0) bad_done++;
      @(negedge clk);
    end
    for (int i = 0; i < exp_bytes.size(); i++) begin
      for (int k = 0; k < 8; k++) got[k] = samp[(i*10 + 1 + k)*CPB + CPB/2];
      chk($sformatf("%s byte%0d", tag, i), got, exp_bytes[i]);
    end
    chk({tag, " cycle-exact waveform errors"}, bad_wave, 0);
    chk({tag, " busy/ready during frame errors"}, bad_busy, 0);
    chk({tag, " early done pulses"}, bad_done, 0);
    chk({tag, " end busy"}, tx_busy, 1'b0);
    chk({tag, " end ready"}, tx_ready, 1'b1);
    chk({tag, " end done"}, tx_done, 1'b1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    logic [8*MAXB-1:0] da, db;
    int la, lb, lr, bad_idle;

    s = "123456789";
    cu_crc_in = 8'h00;
    for (int i = 0; i < s.len(); i++) begin
      cu_byte_in = s[i];
      #1;
      cu_crc_in = cu_crc_out;
    end
    chk("crc8 check string", cu_crc_in, 8'hF4);

    repeat (3) @(negedge clk);
    chk("reset line", tx_line, 1'b1);
    chk("reset busy", tx_busy, 1'b0);
    chk("reset ready", tx_ready, 1'b0);
    chk("reset done", tx_done, 1'b0);
    chk("reset len_err", tx_len_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", tx_ready, 1'b1);

    start_frame("min", '0, 0, 0, 0);
    chk("min wave length", exp_wave.size(), 168);
    check_frame("min", 1'b0, 1'b0, '0, 0, 0, 0);
    @(negedge clk);
    chk("min done single", tx_done, 1'b0);
    chk("min ready after", tx_ready, 1'b1);

    start_frame("pay", (8*MAXB)'(16'hBEA5), 2, 1, 2);
    check_frame("pay", 1'b0, 1'b0, '0, 0, 0, 0);
    @(negedge clk);

    tx_len   = LW'(17);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("lenerr pulse", tx_len_err, 1'b1);
    chk("lenerr line", tx_line, 1'b1);
    chk("lenerr busy", tx_busy, 1'b0);
    chk("lenerr ready", tx_ready, 1'b1);
    bad_idle = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_len_err !== 1'b0 || tx_line !== 1'b1 || tx_busy !== 1'b0) bad_idle++;
    end
    chk("lenerr quiet afterwards", bad_idle, 0);

    da = {$urandom, $urandom, $urandom, $urandom};
    db = {$urandom, $urandom, $urandom, $urandom};
    la = $urandom_range(1, MAXB);
    lb = $urandom_range(0, MAXB);
    start_frame("b2b1", da, la, 3, 1);
    check_frame("b2b1", 1'b1, 1'b1, db, lb, 2, 3);
    build_expect(db, lb, 2, 3);
    @(negedge clk);
    check_frame("b2b2", 1'b0, 1'b0, '0, 0, 0, 0);
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      da = {$urandom, $urandom, $urandom, $urandom};
      lr = (r == 0) ? MAXB : int'($urandom_range(0, MAXB));
      start_frame($sformatf("rnd%0d", r), da, lr, $urandom_range(0, 3), $urandom_range(0, 3));
      check_frame($sformatf("rnd%0d", r), 1'b0, 1'b0, '0, 0, 0, 0);
      @(negedge clk);
    end

    start_frame("rstmid", (8*MAXB)'(16'hBEA5), 2, 1, 2);
    tx_valid = 1'b0;
    repeat (137) @(negedge clk);
    chk("rstmid payload bit3 low", tx_line, exp_wave[137]);
    rst = 1'b1;
    #1;
    chk("rstmid async line", tx_line, 1'b1);
    chk("rstmid async busy", tx_busy, 1'b0);
    chk("rstmid async ready", tx_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid ready first clock", tx_ready, 1'b1);
    chk("rstmid line idle", tx_line, 1'b1);
    da = {$urandom, $urandom, $urandom, $urandom};
    start_frame("postrst", da, 5, 2, 1);
    check_frame("postrst", 1'b0, 1'b0, '0, 0, 0, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_tx_engine.md
Name: frame_tx_engine

Overview:
Parametrised successor to the network controller's fixed-width serial transmitter. Accepts one frame per valid/ready handshake, then serialises it onto tx_line as UART-style 8N1 bytes: SYNC, header, length, payload bytes and a CRC-8 trailer, followed by an idle inter-frame gap. Payload width, ID width, bit rate and gap length are configurable. Adds length checking and a done pulse, which the fixed-width transmitter lacks. Sits between main_controller_brain and the GPIO TX pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); must be >= 2
MAX_BYTES, 16, maximum payload bytes per frame
ID_W, 2, node ID width; legal range 1..4
GAP_BITS, 2, idle (high) bit times after the CRC stop bit
LEN_W, $clog2(MAX_BYTES+1), derived, length field width; must be <= 8

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
tx_valid  in  1  frame request
tx_ready  out  1  engine can accept a frame
tx_data  in  8*MAX_BYTES  payload; byte i = tx_data[8i+7:8i]; byte 0 is sent first
tx_len  in  LEN_W  payload byte count, 0..MAX_BYTES
tx_dest_id  in  ID_W  destination node
my_id  in  ID_W  source node ID
tx_line  out  1  serial line; idles high
tx_busy  out  1  frame in progress, including the gap
tx_done  out  1  one-cycle pulse when a frame completes
tx_len_err  out  1  one-cycle pulse when a request is rejected

Behaviour:
- Reset values, applied immediately on rst, including mid-frame:
  - tx_line=1, tx_busy=0, tx_done=0, tx_len_err=0, tx_ready=0 while rst is high.
  - FSM goes to IDLE; all counters and the CRC register clear.
  - No partial byte is completed after reset.
- tx_ready=1 only in IDLE with rst low. It is a registered output.
- Accept: tx_valid & tx_ready at a rising edge.
  - tx_data, tx_len, tx_dest_id and my_id are latched on that edge.
  - Later changes to the inputs have no effect on the frame in flight.
- Length error: if tx_len > MAX_BYTES on an accept edge:
  - Nothing is latched and no frame is sent.
  - tx_len_err=1 for the next cycle.
  - tx_ready stays 1 and the FSM stays in IDLE.
- Frame byte order:
  - idx0 SYNC=0x7E
  - idx1 HDR={dest zero-padded to 4b, src zero-padded to 4b}, dest in bits[7:4]
  - idx2 LEN={zero-pad, tx_len}
  - idx3..idx(2+len) payload
  - idx(3+len) CRC
- len=0 is legal: the frame is SYNC, HDR, LEN, CRC.
- Byte encoding: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- CRC-8: poly 0x07, init 0x00, no reflection, no final XOR.
  - Computed over HDR, LEN and payload bytes; SYNC is excluded.
  - Each byte is folded into the CRC when it is loaded into the shift register.
  - The CRC byte is sent MSB-first-computed but LSB-first on the line, like every other byte.
- FSM states: IDLE -> START -> DATA -> STOP -> (next byte ? START : GAP) -> IDLE.
  - Bit counter runs 0..7 in DATA.
  - Byte index register is 0..MAX_BYTES+3.
  - Baud counter runs 0..CLKS_PER_BIT-1 and reloads at every bit boundary.
- Latency: accept at edge t.
  - tx_busy=1 and tx_ready=0 from t+1.
  - tx_line falls (SYNC start bit) at t+1.
- Duration: the frame occupies ((4+len)*10 + GAP_BITS)*CLKS_PER_BIT cycles from t+1.
- Completion: in the first cycle after the gap ends, all of the following hold at once:
  - tx_busy=0
  - tx_ready=1
  - tx_done=1 for that one cycle
- Back-to-back: tx_valid held high means the next accept happens in the tx_done cycle, so the next frame starts the cycle after.
- Unsupported: tx_valid during busy is ignored. There is no queueing and no abort input.
- All outputs are registered; tx_line is glitch-free.

Decomposition:
- Shared package net_pkg:
  - SYNC_BYTE=8'h7E, CRC8_POLY=8'h07, CRC8_INIT=8'h00
  - FSM state enum tx_state_t
  - Fixed-field index constants IDX_SYNC, IDX_HDR, IDX_LEN, IDX_PAY0
  - Frame-byte overhead constant 4
- One sub-module, crc8_update: combinational, inputs crc_in[7:0] and byte_in[7:0], output crc_out. The rx side reuses it for checking.

Test Plan:
- CRC unit check: run crc8_update over ASCII "123456789" -> final CRC 0xF4.
- Minimal frame: CLKS_PER_BIT=4, dest=0, my_id=0, len=0, accept once ->
  - Line carries bytes 7E,00,00,00.
  - 40 bit times, then 2 idle bit times: 168 cycles with tx_busy=1.
  - tx_done pulses exactly once, then tx_ready=1.
- Payload frame: dest=1, my_id=2, len=2, data[15:0]=16'hBEA5 ->
  - Decoded bytes 7E,12,02,A5,BE,CRC.
  - CRC matches the reference model over 12,02,A5,BE.
  - Each bit is stable for exactly 4 cycles.
- Length error: MAX_BYTES=16, tx_len=17, tx_valid=1 for one cycle ->
  - tx_len_err pulses the next cycle.
  - tx_line stays 1 and tx_busy stays 0.
- Back-to-back and input stability:
  - Hold tx_valid high and change tx_data mid-frame.
  - First frame must carry the latched data.
  - Second frame's start bit appears the cycle after the tx_done pulse.
- Reset mid-frame: assert rst during payload bit 3 ->
  - tx_line=1 and tx_busy=0 in the same cycle, asynchronously.
  - After release, tx_ready=1 on the first clock.
  - A new frame transmits correctly.
